fp_div_seq: RTL and testbench

- Parametrised, multi-cycle IEEE-754-style floating-point divider. Successor to the fixed single-precision divider.
- Generalised to any exponent/mantissa width. Adds a start/ready/done handshake, hidden-bit handling, round-to-nearest-even, overflow/underflow detection and exception flags.
- Sits in the floating-point unit beside the adder/multiplier and is driven by the same operand-issue logic.

---
 rtl/fp_pkg.sv | 39 +++
 rtl/fp_classify.sv | 22 ++
 rtl/fp_div_seq.sv | 178 +++++++++++++++++
 tb/tb_fp_div_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand classes, divider states, flag
// bit positions and width-generic helpers for bias and canonical NaN.
package fp_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_DIV,
    ST_NORM,
    ST_DONE
  } div_state_e;

  localparam int FLAG_INV = 3;
  localparam int FLAG_DZ  = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_UNF = 0;

  localparam int FP_MAX_W = 128;

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  // Quiet NaN: sign 0, exponent all-ones, only the fraction MSB set.
  function automatic logic [FP_MAX_W-1:0] fp_canon_nan(input int unsigned exp_w,
                                                       input int unsigned man_w);
    logic [FP_MAX_W-1:0] one;
    one = FP_MAX_W'(1);
    return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand class decode; subnormals are treated as zero.
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W-1:0] exp,
  input  logic [MAN_W-1:0] frac,
  output fp_class_e        cls
);

  always_comb begin
    if (exp == '0)
      cls = CLS_ZERO;
    else if (exp == '1)
      cls = (frac == '0) ? CLS_INF : CLS_NAN;
    else
      cls = CLS_NORM;
  end

endmodule

// File: rtl/fp_div_seq.sv
// Multi-cycle floating-point divider: restoring mantissa division, one
// quotient bit per cycle, round-to-nearest-even, flush-to-zero on underflow.
module fp_div_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  output logic                   ready,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   out,
  output logic [3:0]             flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int QW = MAN_W + 3;
  localparam int CW = $clog2(MAN_W + 4);
  localparam int EW = EXP_W + 2;

  localparam logic signed [EW-1:0] BIAS_E  = EW'(fp_bias(EXP_W));
  localparam logic signed [EW-1:0] EMAX    = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EZERO   = '0;
  localparam logic        [W-1:0]  NAN_VAL = W'(fp_canon_nan(EXP_W, MAN_W));
  localparam logic        [CW-1:0] LAST_IT = CW'(QW - 1);

  div_state_e state, state_n;

  logic [W-1:0]          a_r, b_r;
  fp_class_e             cls_a, cls_b;
  logic                  sgn;
  logic [MAN_W:0]        mb;
  logic [MAN_W+1:0]      rem, rem_sub;
  logic                  ge;
  logic [QW-1:0]         q;
  logic signed [EW-1:0]  e;
  logic [CW-1:0]         cnt;

  logic                  special;
  logic [W-1:0]          sp_res, nm_res;
  logic [3:0]            sp_flags, nm_flags;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .exp  (a_r[W-2:MAN_W]),
    .frac (a_r[MAN_W-1:0]),
    .cls  (cls_a)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .exp  (b_r[W-2:MAN_W]),
    .frac (b_r[MAN_W-1:0]),
    .cls  (cls_b)
  );

  assign sgn   = a_r[W-1] ^ b_r[W-1];
  assign mb    = {1'b1, b_r[MAN_W-1:0]};
  assign ready = (state == ST_IDLE);
  assign done  = (state == ST_DONE);

  // inf/0 falls through to the inf/finite row, so it raises no flag.
  always_comb begin
    special  = 1'b1;
    sp_res   = '0;
    sp_flags = '0;
    if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
        (cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
        (cls_a == CLS_INF  && cls_b == CLS_INF)) begin
      sp_res             = NAN_VAL;
      sp_flags[FLAG_INV] = 1'b1;
    end else if (cls_b == CLS_ZERO && cls_a != CLS_INF) begin
      sp_res            = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      sp_flags[FLAG_DZ] = 1'b1;
    end else if (cls_a == CLS_INF) begin
      sp_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (cls_a == CLS_ZERO || cls_b == CLS_INF) begin
      sp_res = {sgn, {(W-1){1'b0}}};
    end else begin
      special = 1'b0;
    end
  end

  always_comb begin
    ge      = (rem >= {1'b0, mb});
    rem_sub = ge ? (rem - {1'b0, mb}) : rem;
  end

  // Normalise, round and range-check the finished quotient in one cycle.
  logic                 norm, g_bit, r_bit, s_bit, rup, carry;
  logic [MAN_W:0]       mant;
  logic [MAN_W+1:0]     sum;
  logic signed [EW-1:0] dec, inc, e_n;

  always_comb begin
    norm  = q[QW-1];
    mant  = norm ? q[QW-1:2] : q[QW-2:1];
    g_bit = norm ? q[1] : q[0];
    r_bit = norm ? q[0] : 1'b0;
    s_bit = |rem;
    rup   = g_bit & (r_bit | s_bit | mant[0]);
    sum   = {1'b0, mant} + {{(MAN_W+1){1'b0}}, rup};
    carry = sum[MAN_W+1];
    dec   = {{(EW-1){1'b0}}, ~norm};
    inc   = {{(EW-1){1'b0}}, carry};
    e_n   = e - dec + inc;
    nm_flags = '0;
    if (e_n >= EMAX) begin
      nm_res             = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      nm_flags[FLAG_OVF] = 1'b1;
    end else if (e_n <= EZERO) begin
      nm_res             = {sgn, {(W-1){1'b0}}};
      nm_flags[FLAG_UNF] = 1'b1;
    end else begin
      nm_res = {sgn, e_n[EXP_W-1:0], carry ? {MAN_W{1'b0}} : sum[MAN_W-1:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (start) state_n = ST_PREP;
      ST_PREP: state_n = special ? ST_DONE : ST_DIV;
      ST_DIV:  if (cnt == LAST_IT) state_n = ST_NORM;
      ST_NORM: state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      rem   <= '0;
      q     <= '0;
      e     <= '0;
      cnt   <= '0;
      out   <= '0;
      flags <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          a_r <= in_a;
          b_r <= in_b;
        end
        ST_PREP: begin
          rem <= {1'b0, 1'b1, a_r[MAN_W-1:0]};
          q   <= '0;
          cnt <= '0;
          e   <= $signed({2'b00, a_r[W-2:MAN_W]}) - $signed({2'b00, b_r[W-2:MAN_W]}) + BIAS_E;
          if (special) begin
            out   <= sp_res;
            flags <= sp_flags;
          end
        end
        ST_DIV: begin
          rem <= {rem_sub[MAN_W:0], 1'b0};
          q   <= {q[QW-2:0], ge};
          cnt <= cnt + CW'(1);
        end
        ST_NORM: begin
          out   <= nm_res;
          flags <= nm_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq: single precision instance plus a
// double precision instance sharing clock and reset.
module tb_fp_div_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start;
  logic [31:0] in_a, in_b, out;
  logic        ready, done;
  logic [3:0]  flags;

  logic        start64;
  logic [63:0] a64, b64, out64;
  logic        ready64, done64;
  logic [3:0]  flags64;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  fp_div_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in_a  (in_a),
    .in_b  (in_b),
    .ready (ready),
    .done  (done),
    .out   (out),
    .flags (flags)
  );

  fp_div_seq #(.EXP_W(11), .MAN_W(52)) dut64 (
    .clk   (clk),
    .rst   (rst),
    .start (start64),
    .in_a  (a64),
    .in_b  (b64),
    .ready (ready64),
    .done  (done64),
    .out   (out64),
    .flags (flags64)
  );

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic [3:0] flg,
                        output int lat);
    @(negedge clk);
    in_a  = a;
    in_b  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out;
    flg = flags;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL timeout a=%h b=%h: done=%b required 1", a, b, done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; start64 = 1'b0;
    in_a = '0; in_b = '0; a64 = '0; b64 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (ready !== 1'b1)  begin errors++; $display("FAIL reset_ready: got %b required 1", ready); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    checks++; if (out !== 32'h0)   begin errors++; $display("FAIL reset_out: got %h required 0", out); end
    checks++; if (flags !== 4'h0)  begin errors++; $display("FAIL reset_flags: got %h required 0", flags); end
  endtask

  task automatic run_table(input string name, input vec_t v[]);
    logic [31:0] r;
    logic [3:0]  f;
    int          l;
    foreach (v[i]) begin
      run_op(v[i].a, v[i].b, r, f, l);
      checks++;
      if (r !== v[i].res) begin
        errors++; $display("FAIL %s[%0d]_out: got %h required %h", name, i, r, v[i].res);
      end
      checks++;
      if (f !== v[i].flg) begin
        errors++; $display("FAIL %s[%0d]_flags: got %h required %h", name, i, f, v[i].flg);
      end
      checks++;
      if (l != v[i].lat) begin
        errors++; $display("FAIL %s[%0d]_latency: got %0d required %0d", name, i, l, v[i].lat);
      end
    end
  endtask

  task automatic test_normal;
    vec_t v[] = '{
      '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 29},
      '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 29},
      '{32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 29}
    };
    run_table("normal", v);
  endtask

  task automatic test_special;
    vec_t v[] = '{
      '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 2},
      '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 2},
      '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 2},
      '{32'hFF800001, 32'h3F800000, 32'h7FC00000, 4'b1000, 2},
      '{32'h7F800000, 32'h00000000, 32'h7F800000, 4'b0000, 2},
      '{32'h00000000, 32'hFF800000, 32'h80000000, 4'b0000, 2}
    };
    run_table("special", v);
  endtask

  task automatic test_range;
    vec_t v[] = '{
      '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 29},
      '{32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 29}
    };
    run_table("range", v);
  endtask

  task automatic test_ignored_start;
    int lat;
    int extra;
    @(negedge clk);
    in_a = 32'h40C00000; in_b = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      if (lat == 3 || lat == 10) begin
        in_a = 32'h3F800000; in_b = 32'h00000000; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    checks++; if (out !== 32'h40400000) begin errors++; $display("FAIL ignored_out: got %h required 40400000", out); end
    checks++; if (lat != 29) begin errors++; $display("FAIL ignored_latency: got %0d required 29", lat); end
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL ignored_extra_done: got %0d required 0", extra); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r;
    logic [3:0]  f;
    int          l;
    run_op(32'h3F800000, 32'h00000000, r, f, l);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b required 1", ready); end
    run_op(32'h40C00000, 32'h40000000, r, f, l);
    checks++; if (r !== 32'h40400000) begin errors++; $display("FAIL b2b_out: got %h required 40400000", r); end
    checks++; if (l != 29) begin errors++; $display("FAIL b2b_latency: got %0d required 29", l); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (out !== 32'h40400000) begin errors++; $display("FAIL b2b_hold: got %h required 40400000", out); end
  endtask

  task automatic test_reset_abort;
    int seen;
    @(negedge clk);
    in_a = 32'h3F800000; in_b = 32'h40400000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (ready !== 1'b1)  begin errors++; $display("FAIL abort_ready: got %b required 1", ready); end
    checks++; if (out !== 32'h0)   begin errors++; $display("FAIL abort_out: got %h required 0", out); end
    checks++; if (flags !== 4'h0)  begin errors++; $display("FAIL abort_flags: got %h required 0", flags); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_done: got %0d pulses required 0", seen); end
  endtask

  task automatic test_double;
    int lat;
    @(negedge clk);
    a64 = 64'h4018000000000000; b64 = 64'h4000000000000000; start64 = 1'b1;
    @(posedge clk); #1;
    start64 = 1'b0;
    lat = 1;
    while (!done64 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (done64 !== 1'b1) begin errors++; $display("FAIL dp_timeout: done=%b required 1", done64); end
    checks++; if (out64 !== 64'h4008000000000000) begin errors++; $display("FAIL dp_out: got %h required 4008000000000000", out64); end
    checks++; if (flags64 !== 4'h0) begin errors++; $display("FAIL dp_flags: got %h required 0", flags64); end
    checks++; if (lat != 58) begin errors++; $display("FAIL dp_latency: got %0d required 58", lat); end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_special;
    test_range;
    test_ignored_start;
    test_back_to_back;
    test_reset_abort;
    test_double;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
